// File: rtl/huffman_code_builder.sv
// -----------------------------------------------------------------------------
// huffman_code_builder
//
// Purpose:
//   Collects a stream of symbols while `start` is high, counts the frequency
//   of up to MAX_SYM distinct symbols (slots filled in first-appearance order),
//   builds a Huffman code from those counts with a deterministic tie-break
//   (lowest weight, then lowest slot index), assigns canonical codewords and
//   exposes a per-slot table (symbol, length, codeword) through a
//   combinational read port selected by `addr` once `done` is high.
//
// Configuration macro:
//   HUFF_CNT_SAT_EN  defined   -> frequency counters saturate at 2^CNT_W-1
//                    undefined -> frequency counters wrap modulo 2^CNT_W
//
// Ports:
//   clk         in   1       rising-edge clock
//   rst         in   1       asynchronous active-low reset
//   start       in   1       high = collect `indata` every clock; a rising
//                            edge (or any high level while idle) starts a job
//   indata      in   DATA_W  symbol sampled on each clk edge while start=1
//   addr        in   6       table entry select (valid 0..MAX_SYM-1)
//   done        out  1       table valid (level)
//   out_result  out  DATA_W  symbol value of entry `addr`
//   out_L       out  3       code length of entry `addr`
//   out_W       out  8       canonical codeword of entry `addr`, right-aligned
// -----------------------------------------------------------------------------
module huffman_code_builder #(
    parameter int DATA_W  = 8,
    parameter int MAX_SYM = 8,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] indata,
    input  logic [5:0]        addr,
    output logic              done,
    output logic [DATA_W-1:0] out_result,
    output logic [2:0]        out_L,
    output logic [7:0]        out_W
);

    localparam int IDX_W  = $clog2(MAX_SYM);
    localparam int NV_W   = $clog2(MAX_SYM + 1);
    localparam int WGT_W  = CNT_W + 3;
    localparam int LEN_W  = 3;
    localparam int CODE_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_MERGE   = 3'd2,
        S_CODE    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t             r_state;
    logic               r_start_d;
    logic               r_done;
    logic [NV_W-1:0]    r_nvalid;
    logic               r_vld  [MAX_SYM];
    logic [DATA_W-1:0]  r_sym  [MAX_SYM];
    logic [CNT_W-1:0]   r_cnt  [MAX_SYM];
    logic               r_act  [MAX_SYM];
    logic [WGT_W-1:0]   r_wgt  [MAX_SYM];
    logic [IDX_W-1:0]   r_grp  [MAX_SYM];
    logic [LEN_W-1:0]   r_len  [MAX_SYM];
    logic [CODE_W-1:0]  r_code [MAX_SYM];
    logic [LEN_W-1:0]   r_cur_len;
    logic [CODE_W:0]    r_base;

    logic               w_new_job;
    logic               w_hit;
    logic [IDX_W-1:0]   w_hit_idx;
    logic               w_free;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_min2_ok;
    logic [IDX_W-1:0]   w_min1;
    logic [IDX_W-1:0]   w_min2;
    logic [IDX_W-1:0]   w_lo;
    logic [IDX_W-1:0]   w_hi;
    logic [WGT_W-1:0]   w_sum;
    logic               w_take     [MAX_SYM];
    logic [CODE_W-1:0]  w_code_asg [MAX_SYM];
    logic [CODE_W:0]    w_base_next;
    logic               w_rd_ok;

    // Job start: any start while idle, or a rising edge of start once done.
    always_comb begin
        w_new_job = ((r_state == S_IDLE) && start) ||
                    ((r_state == S_DONE) && start && !r_start_d);
    end

    // Symbol lookup among valid slots and the next counter value for a hit.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = MAX_SYM - 1; i >= 0; i--) begin
            if (r_vld[i] && (r_sym[i] == indata)) begin
                w_hit     = 1'b1;
                w_hit_idx = IDX_W'(i);
            end else begin
                w_hit     = w_hit;
                w_hit_idx = w_hit_idx;
            end
        end
        w_free = (r_nvalid < NV_W'(MAX_SYM));
`ifdef HUFF_CNT_SAT_EN
        w_cnt_inc = (r_cnt[w_hit_idx] == {CNT_W{1'b1}}) ? r_cnt[w_hit_idx]
                                                         : r_cnt[w_hit_idx] + CNT_W'(1);
`else
        w_cnt_inc = r_cnt[w_hit_idx] + CNT_W'(1);
`endif
    end

    // Two smallest active nodes; the ascending scan with strict '<' keeps the
    // lowest slot index on equal weights.
    always_comb begin
        logic             v_ok1;
        logic             v_ok2;
        logic [IDX_W-1:0] v_i1;
        logic [IDX_W-1:0] v_i2;
        v_ok1 = 1'b0;
        v_ok2 = 1'b0;
        v_i1  = '0;
        v_i2  = '0;
        for (int i = 0; i < MAX_SYM; i++) begin
            if (r_act[i] && (!v_ok1 || (r_wgt[i] < r_wgt[v_i1]))) begin
                v_ok1 = 1'b1;
                v_i1  = IDX_W'(i);
            end else begin
                v_ok1 = v_ok1;
            end
        end
        for (int i = 0; i < MAX_SYM; i++) begin
            if (r_act[i] && (IDX_W'(i) != v_i1) &&
                (!v_ok2 || (r_wgt[i] < r_wgt[v_i2]))) begin
                v_ok2 = 1'b1;
                v_i2  = IDX_W'(i);
            end else begin
                v_ok2 = v_ok2;
            end
        end
        w_min1    = v_i1;
        w_min2    = v_i2;
        w_min2_ok = v_ok1 && v_ok2;
        w_lo      = (v_i1 < v_i2) ? v_i1 : v_i2;
        w_hi      = (v_i1 < v_i2) ? v_i2 : v_i1;
        w_sum     = r_wgt[v_i1] + r_wgt[v_i2];
    end

    // Canonical codes for every slot whose length equals the current level:
    // consecutive codes from the running base, in slot order. The base for the
    // next level is (base + entries at this level) shifted up by one.
    always_comb begin
        logic [CODE_W:0] v_off;
        v_off = '0;
        for (int i = 0; i < MAX_SYM; i++) begin
            w_take[i]     = r_vld[i] && (r_len[i] == r_cur_len);
            w_code_asg[i] = r_base[CODE_W-1:0] + v_off[CODE_W-1:0];
            if (w_take[i]) begin
                v_off = v_off + (CODE_W + 1)'(1);
            end else begin
                v_off = v_off;
            end
        end
        w_base_next = (r_base + v_off) << 1'd1;
    end

    // Control FSM together with the slot table, merge and code state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_start_d <= 1'b0;
            r_done    <= 1'b0;
            r_nvalid  <= '0;
            r_cur_len <= '0;
            r_base    <= '0;
            for (int i = 0; i < MAX_SYM; i++) begin
                r_vld[i]  <= 1'b0;
                r_sym[i]  <= '0;
                r_cnt[i]  <= '0;
                r_act[i]  <= 1'b0;
                r_wgt[i]  <= '0;
                r_grp[i]  <= '0;
                r_len[i]  <= '0;
                r_code[i] <= '0;
            end
        end else begin
            r_start_d <= start;
            if (w_new_job) begin
                // Clear the table; this edge's sample becomes slot 0.
                r_state   <= S_COLLECT;
                r_done    <= 1'b0;
                r_nvalid  <= NV_W'(1);
                r_cur_len <= '0;
                r_base    <= '0;
                for (int i = 0; i < MAX_SYM; i++) begin
                    r_vld[i]  <= 1'b0;
                    r_sym[i]  <= '0;
                    r_cnt[i]  <= '0;
                    r_act[i]  <= 1'b0;
                    r_wgt[i]  <= '0;
                    r_grp[i]  <= '0;
                    r_len[i]  <= '0;
                    r_code[i] <= '0;
                end
                r_vld[0] <= 1'b1;
                r_sym[0] <= indata;
                r_cnt[0] <= CNT_W'(1);
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_COLLECT: begin
                        if (start) begin
                            if (w_hit) begin
                                r_cnt[w_hit_idx] <= w_cnt_inc;
                            end else if (w_free) begin
                                r_vld[r_nvalid[IDX_W-1:0]] <= 1'b1;
                                r_sym[r_nvalid[IDX_W-1:0]] <= indata;
                                r_cnt[r_nvalid[IDX_W-1:0]] <= CNT_W'(1);
                                r_nvalid <= r_nvalid + NV_W'(1);
                            end
                            // otherwise the table is full and the sample is dropped
                        end else begin
                            // Every valid slot starts as its own single-leaf node.
                            r_state <= S_MERGE;
                            for (int i = 0; i < MAX_SYM; i++) begin
                                r_act[i] <= r_vld[i];
                                r_wgt[i] <= WGT_W'(r_cnt[i]);
                                r_grp[i] <= IDX_W'(i);
                                r_len[i] <= '0;
                            end
                        end
                    end
                    S_MERGE: begin
                        if (w_min2_ok) begin
                            // Merged node lives in the lower slot; every leaf of
                            // both groups moves one level deeper.
                            r_wgt[w_lo] <= w_sum;
                            r_act[w_hi] <= 1'b0;
                            for (int j = 0; j < MAX_SYM; j++) begin
                                if (r_vld[j] && ((r_grp[j] == w_lo) || (r_grp[j] == w_hi))) begin
                                    r_len[j] <= r_len[j] + 3'd1;
                                    r_grp[j] <= w_lo;
                                end
                            end
                        end else if (r_nvalid == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // A lone symbol still needs a 1-bit code.
                            if (r_nvalid == NV_W'(1)) begin
                                r_len[0] <= 3'd1;
                            end
                            r_state   <= S_CODE;
                            r_cur_len <= 3'd1;
                            r_base    <= '0;
                        end
                    end
                    S_CODE: begin
                        for (int i = 0; i < MAX_SYM; i++) begin
                            if (w_take[i]) begin
                                r_code[i] <= w_code_asg[i];
                            end
                        end
                        r_base <= w_base_next;
                        if (r_cur_len == 3'd7) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cur_len <= r_cur_len + 3'd1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_DONE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign done = r_done;

    // Combinational table read; anything outside the finished table reads 0.
    always_comb begin
        w_rd_ok = r_done && (addr < 6'(r_nvalid));
        if (w_rd_ok) begin
            out_result = r_sym[addr[IDX_W-1:0]];
            out_L      = r_len[addr[IDX_W-1:0]];
            out_W      = r_code[addr[IDX_W-1:0]];
        end else begin
            out_result = '0;
            out_L      = '0;
            out_W      = '0;
        end
    end

endmodule

// File: tb/tb_huffman_code_builder.sv
module tb_huffman_code_builder;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] indata;
    logic [5:0] addr;
    logic       done;
    logic [7:0] out_result;
    logic [2:0] out_L;
    logic [7:0] out_W;

    always #5 clk = ~clk;

    huffman_code_builder dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .indata     (indata),
        .addr       (addr),
        .done       (done),
        .out_result (out_result),
        .out_L      (out_L),
        .out_W      (out_W)
    );

    typedef struct {
        int a;
        int d;
        int s;
        int l;
        int w;
    } exp_t;

    exp_t       sb[$];
    logic       rd_req = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    logic [7:0] stim_q[$];
    int         m_n;
    int         m_sym  [8];
    int         m_cnt  [8];
    int         m_len  [8];
    int         m_code [8];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever a read is presented, pop the expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rd_req) begin
                if (sb.size() == 0) begin
                    check("scoreboard_empty", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("done@addr%0d", e.a), int'(done), e.d);
                    check($sformatf("sym@addr%0d", e.a), int'(out_result), e.s);
                    check($sformatf("len@addr%0d", e.a), int'(out_L), e.l);
                    check($sformatf("code@addr%0d", e.a), int'(out_W), e.w);
                end
            end
        end
    end

    // Reference: count, merge groups as leaf bitmasks, then canonical codes.
    task automatic model_run();
        int         alive[8];
        int         wgt[8];
        logic [7:0] mem[8];
        int         a, b, lo, hi, code, prev;
        bit         first, found;
        m_n = 0;
        for (int i = 0; i < 8; i++) begin
            m_sym[i] = 0; m_cnt[i] = 0; m_len[i] = 0; m_code[i] = 0;
        end
        foreach (stim_q[k]) begin
            found = 0;
            for (int j = 0; j < m_n; j++) begin
                if (m_sym[j] == int'(stim_q[k])) begin
                    found = 1;
`ifdef HUFF_CNT_SAT_EN
                    m_cnt[j] = (m_cnt[j] < 255) ? m_cnt[j] + 1 : 255;
`else
                    m_cnt[j] = (m_cnt[j] + 1) % 256;
`endif
                end
            end
            if (!found && m_n < 8) begin
                m_sym[m_n] = int'(stim_q[k]);
                m_cnt[m_n] = 1;
                m_n++;
            end
        end
        for (int i = 0; i < 8; i++) begin
            alive[i] = (i < m_n) ? 1 : 0;
            wgt[i]   = m_cnt[i];
            mem[i]   = 8'(1 << i);
        end
        for (int m = 0; m < m_n - 1; m++) begin
            a = -1;
            for (int i = 0; i < 8; i++)
                if (alive[i] != 0 && (a < 0 || wgt[i] < wgt[a])) a = i;
            b = -1;
            for (int i = 0; i < 8; i++)
                if (alive[i] != 0 && i != a && (b < 0 || wgt[i] < wgt[b])) b = i;
            lo = (a < b) ? a : b;
            hi = (a < b) ? b : a;
            for (int j = 0; j < 8; j++)
                if (mem[a][j] || mem[b][j]) m_len[j]++;
            mem[lo]   = mem[a] | mem[b];
            wgt[lo]   = wgt[a] + wgt[b];
            alive[hi] = 0;
        end
        if (m_n == 1) m_len[0] = 1;
        code = 0; prev = 0; first = 1;
        for (int l = 1; l <= 7; l++) begin
            for (int i = 0; i < m_n; i++) begin
                if (m_len[i] == l) begin
                    if (first) begin
                        code  = 0;
                        first = 0;
                    end else begin
                        code = (code + 1) << (l - prev);
                    end
                    m_code[i] = code;
                    prev = l;
                end
            end
        end
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b0; start = 1'b0; indata = 8'd0; addr = 6'd0;
        repeat (cyc) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic send_stream();
        foreach (stim_q[k]) begin
            @(negedge clk);
            start  = 1'b1;
            indata = stim_q[k];
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        @(posedge clk); #1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("done_within_20", int'(done), 1);
    endtask

    task automatic read_entry(input int a, input int d, input int s, input int l, input int w);
        exp_t e;
        @(posedge clk); #1;
        addr = 6'(a);
        e.a = a; e.d = d; e.s = s; e.l = l; e.w = w;
        sb.push_back(e);
        rd_req = 1'b1;
        @(negedge clk); #1;
        rd_req = 1'b0;
    endtask

    task automatic read_model_table();
        for (int a = 0; a < 10; a++) begin
            if (a < m_n) read_entry(a, 1, m_sym[a], m_len[a], m_code[a]);
            else         read_entry(a, 1, 0, 0, 0);
        end
        read_entry(63, 1, 0, 0, 0);
    endtask

    task automatic run_model_job();
        send_stream();
        model_run();
        wait_done();
        read_model_table();
    endtask

    initial begin
        int         e_s[8] = '{11, 22, 44, 33, 55, 0, 66, 77};
        int         e_l[8] = '{4, 3, 2, 3, 2, 4, 4, 4};
        int         e_w[8] = '{12, 4, 0, 5, 1, 13, 14, 15};
        int         pat[8] = '{11, 22, 44, 44, 33, 55, 55, 55};
        logic [7:0] pool[10];
        int         len;

        // Reset state: nothing valid, all reads zero.
        do_reset(10);
        check("reset_done", int'(done), 0);
        read_entry(0, 0, 0, 0, 0);
        read_entry(3, 0, 0, 0, 0);
        read_entry(7, 0, 0, 0, 0);
        read_entry(63, 0, 0, 0, 0);

        // Reference 40-symbol stream with fixed expected table.
        stim_q.delete();
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) stim_q.push_back(8'(pat[k]));
        stim_q.push_back(8'd0);  stim_q.push_back(8'd0);  stim_q.push_back(8'd0);
        stim_q.push_back(8'd66); stim_q.push_back(8'd66); stim_q.push_back(8'd66);
        stim_q.push_back(8'd77); stim_q.push_back(8'd77);
        send_stream();
        wait_done();
        for (int a = 0; a < 8; a++) read_entry(a, 1, e_s[a], e_l[a], e_w[a]);
        read_entry(8, 1, 0, 0, 0);

        // Single symbol.
        stim_q.delete();
        repeat (5) stim_q.push_back(8'd9);
        send_stream();
        wait_done();
        read_entry(0, 1, 9, 1, 0);
        read_entry(1, 1, 0, 0, 0);

        // Equal weights: all length 3, code = slot index.
        stim_q.delete();
        for (int k = 0; k < 8; k++) stim_q.push_back(8'(100 + k));
        send_stream();
        wait_done();
        for (int a = 0; a < 8; a++) read_entry(a, 1, 100 + a, 3, a);

        // Ninth distinct symbol is dropped.
        stim_q.delete();
        for (int k = 0; k < 8; k++) stim_q.push_back(8'(k + 1));
        stim_q.push_back(8'd3); stim_q.push_back(8'd3);
        stim_q.push_back(8'd200);
        stim_q.push_back(8'd200);
        run_model_job();

        // Counter wrap / saturation: 257 of one symbol.
        stim_q.delete();
        repeat (257) stim_q.push_back(8'd42);
        repeat (3) stim_q.push_back(8'd43);
        repeat (3) stim_q.push_back(8'd44);
        run_model_job();

        // Randomized jobs.
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 10; k++) pool[k] = 8'($urandom_range(0, 255));
            len = $urandom_range(1, 40);
            stim_q.delete();
            for (int k = 0; k < len; k++) stim_q.push_back(pool[$urandom_range(0, 9)]);
            run_model_job();
        end

        // Reset during merge, then a fresh job.
        stim_q.delete();
        for (int k = 0; k < 12; k++) stim_q.push_back(8'(k * 3));
        send_stream();
        repeat (3) @(posedge clk);
        do_reset(2);
        #1;
        check("abort_done", int'(done), 0);
        stim_q.delete();
        stim_q.push_back(8'd5); stim_q.push_back(8'd5); stim_q.push_back(8'd6);
        send_stream();
        wait_done();
        read_entry(0, 1, 5, 1, 0);
        read_entry(1, 1, 6, 1, 1);
        read_entry(2, 1, 0, 0, 0);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/huffman_code_builder.md
Name: huffman_code_builder

Overview:
- Collects a stream of 8-bit symbols while `start` is high.
- Counts the frequency of up to 8 distinct symbols and builds a Huffman code from those counts with a deterministic tie-break.
- Assigns canonical codewords and exposes a per-entry table (symbol, length, codeword) that is read by `addr` after `done`.
- Self-contained leaf block, instantiated as the compression front-end.

Parameters:
- DATA_W, 8, symbol width (`indata`, `out_result`).
- MAX_SYM, 8, number of distinct-symbol table slots.
- CNT_W, 8, frequency counter width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- start  in  1  high = collect `indata` every clock; rising edge starts a new job
- indata  in  8  symbol sampled on each clk edge while `start`=1
- addr  in  6  table entry select (valid 0..7)
- done  out  1  table valid; level signal
- out_result  out  8  symbol value of entry `addr`
- out_L  out  3  code length of entry `addr`
- out_W  out  8  canonical codeword of entry `addr`, right-aligned, upper bits 0

Behaviour:
- Reset (`rst`=0, async): state IDLE; `done`=0; all slots invalid; counts, lengths and codes cleared; outputs read 0.
- States and transitions:
  - IDLE → COLLECT on the first clk edge with `start`=1. That edge clears all slots and also collects its `indata`.
  - COLLECT: each edge with `start`=1 looks up `indata` in the valid slots.
    - Hit: increment that slot's count.
    - Miss with a free slot: allocate the next slot in first-appearance order, count=1.
    - Miss with all 8 slots used: drop the sample.
  - COLLECT → MERGE on the first edge with `start`=0.
  - MERGE: one merge per cycle; N-1 merges for N valid slots.
    - Pick the minimum-weight active node; break ties by lowest slot index.
    - Pick the next minimum the same way.
    - The merged node takes the lower slot index; weight = sum (11-bit); the other node is deactivated.
    - Every leaf in both merged groups gets length+1.
  - MERGE → CODE when one active node remains. N=1 forces length 1. N=0 goes straight to DONE.
  - CODE: canonical assignment ordered by (length ascending, slot index ascending).
    - First code = 0.
    - Next code = (prev+1) << (len − prevlen).
    - Processes one length value per cycle, lengths 1..7.
  - DONE: `done`=1; table frozen; stays until the next `start` rising edge, which clears `done` and begins COLLECT.
- Latency: `done` rises ≤ 20 cycles after the first edge with `start`=0.
- Read port is combinational from `addr`.
  - `done`=1 and `addr` < N: outputs show that entry.
  - Otherwise (`addr` ≥ N, `addr` ≥ 8, `done`=0): all three outputs read 0.
- Lengths never exceed 7 (guaranteed for ≤ 8 leaves).
- `start` rising in MERGE/CODE is ignored until DONE.
- Reset mid-operation aborts to IDLE with everything cleared.

Optional Feature:
- Macro HUFF_CNT_SAT_EN.
- Defined: frequency counters saturate at 2^CNT_W−1 (255).
- Undefined: counters wrap modulo 256.
- All other behaviour is identical.

Test Plan:
- Reset held 10 cycles → `done`=0; `out_result`/`out_L`/`out_W` = 0 for any `addr`.
- Stream of 40 symbols: four repeats of [11,22,44,44,33,55,55,55], then 0,0,0,66,66,66,77,77; drop `start`. Expected counts 4,4,8,4,12,3,3,2 in slots 0..7. Then `done` rises within 20 cycles, and `addr` 0..7 read (symbol, L, W):
  - 0: (11, 4, 0x0C)
  - 1: (22, 3, 0x04)
  - 2: (44, 2, 0x00)
  - 3: (33, 3, 0x05)
  - 4: (55, 2, 0x01)
  - 5: (0, 4, 0x0D)
  - 6: (66, 4, 0x0E)
  - 7: (77, 4, 0x0F)
- Single symbol 9 for 5 cycles → `addr` 0 = (9, 1, 0x00); `addr` 1 = all zero.
- Equal weights: 8 distinct symbols once each → all L=3, W = slot index.
- 9th distinct symbol after 8 already seen → dropped; N=8; table unchanged vs. the same stream without it.
- Reset asserted during MERGE, then a new job [5,5,6] → `done` reports only the new job: (5, 1, 0x00), (6, 1, 0x01).
